// File: rtl/pc_fetch_predict_pkg.sv
// Shared widths, direction-counter encodings and the saturating step used by the fetch predictor.
package pc_fetch_predict_pkg;

  localparam int unsigned AWIDTH_DEF = 32;
  localparam int unsigned CTR_W      = 2;
  localparam int unsigned IDX_W      = 2;
  localparam int unsigned NUM_CTR    = 4;
  localparam int unsigned PC_INC     = 4;

  typedef enum logic [CTR_W-1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_e;

  // One training step: move toward the resolved direction, clamping at SNT and ST.
  function automatic logic [CTR_W-1:0] sat_next(input logic [CTR_W-1:0] cur, input logic taken);
    logic [CTR_W-1:0] nxt;
    nxt = cur;
    if (taken && (cur != ST)) begin
      nxt = cur + CTR_W'(1);
    end else if (!taken && (cur != SNT)) begin
      nxt = cur - CTR_W'(1);
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pc_fetch_predict_sat_counter_table.sv
// Four 2-bit saturating direction counters: one combinational read port, one training port.
module sat_counter_table
  import pc_fetch_predict_pkg::*;
#(
  parameter logic [CTR_W-1:0] CTR_INIT = WNT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output logic [CTR_W-1:0] rd_ctr_c,
  input  logic             upd_en,
  input  logic [IDX_W-1:0] upd_idx,
  input  logic             upd_taken
);

  logic [CTR_W-1:0] ctr_q [NUM_CTR];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NUM_CTR; i++) begin
        ctr_q[i] <= CTR_INIT;
      end
    end else if (upd_en) begin
      ctr_q[upd_idx] <= sat_next(ctr_q[upd_idx], upd_taken);
    end
  end

  // Read sees the pre-edge value; no write-to-read bypass.
  assign rd_ctr_c = ctr_q[rd_idx];

endmodule

// File: rtl/pc_fetch_predict.sv
// Fetch PC generator: BTB-guided next-PC prediction, IF/ID capture, and execute-side mispredict redirect.
module pc_fetch_predict
  import pc_fetch_predict_pkg::*;
#(
  parameter int unsigned      AWIDTH   = AWIDTH_DEF,
  parameter logic [AWIDTH-1:0] RESET_PC = '0,
  parameter logic [CTR_W-1:0]  CTR_INIT = WNT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_f,
  input  logic [AWIDTH-1:0] btb_target,
  input  logic              valid_x,
  input  logic              br_x,
  input  logic              br_taken_x,
  input  logic [AWIDTH-1:0] alu_out,
  input  logic [AWIDTH-1:0] PC_x,
  input  logic              pred_taken_x,
  input  logic [AWIDTH-1:0] pred_target_x,
  output logic [AWIDTH-1:0] PC_f,
  output logic [AWIDTH-1:0] PC_d,
  output logic              valid_d,
  output logic              pred_taken_d,
  output logic [AWIDTH-1:0] pred_target_d,
  output logic              redirect,
  output logic              flush
);

  localparam logic [AWIDTH-1:0] INC = AWIDTH'(PC_INC);

  logic [AWIDTH-1:0] pc_plus4_f;
  logic [AWIDTH-1:0] pred_next_f;
  logic [AWIDTH-1:0] redirect_pc;
  logic [CTR_W-1:0]  ctr_f;
  logic              btb_hit;
  logic              pred_taken_f;
  logic              mis_dir;
  logic              mis_tgt;
  logic              mis_alias;
  logic              ctr_upd;

  sat_counter_table #(
    .CTR_INIT (CTR_INIT)
  ) u_ctr (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (PC_f[3:2]),
    .rd_ctr_c  (ctr_f),
    .upd_en    (ctr_upd),
    .upd_idx   (PC_x[3:2]),
    .upd_taken (br_taken_x)
  );

  // Lookup: the BTB returns PC_f+4 on a miss, so any other value is a hit.
  assign pc_plus4_f   = PC_f + INC;
  assign btb_hit      = (btb_target != pc_plus4_f);
  assign pred_taken_f = btb_hit && ctr_f[1];
  assign pred_next_f  = pred_taken_f ? btb_target : pc_plus4_f;

  // Mispredict terms; a non-branch predicted taken is a stale alias in the tables.
  assign mis_dir     = br_x && (br_taken_x != pred_taken_x);
  assign mis_tgt     = br_x && br_taken_x && (alu_out != pred_target_x);
  assign mis_alias   = !br_x && pred_taken_x;
  assign redirect    = valid_x && (mis_dir || mis_tgt || mis_alias);
  assign flush       = redirect;
  assign redirect_pc = (br_x && br_taken_x) ? alu_out : (PC_x + INC);

  assign ctr_upd = valid_x && br_x;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC_f <= RESET_PC;
    end else if (redirect) begin
      PC_f <= redirect_pc;
    end else if (!stall_f) begin
      PC_f <= pred_next_f;
    end
  end

  // IF/ID: a redirect only kills valid; payload holds as don't-care.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      PC_d          <= '0;
      valid_d       <= 1'b0;
      pred_taken_d  <= 1'b0;
      pred_target_d <= '0;
    end else if (redirect) begin
      valid_d <= 1'b0;
    end else if (!stall_f) begin
      PC_d          <= PC_f;
      valid_d       <= 1'b1;
      pred_taken_d  <= pred_taken_f;
      pred_target_d <= pred_next_f;
    end
  end

endmodule

// File: tb/tb_pc_fetch_predict.sv
// Randomized and directed check of pc_fetch_predict against a behavioural fetch/predictor model.
module tb_pc_fetch_predict;

  logic        clk;
  logic        rst;
  logic        stall_f;
  logic [31:0] btb_target;
  logic        valid_x;
  logic        br_x;
  logic        br_taken_x;
  logic [31:0] alu_out;
  logic [31:0] PC_x;
  logic        pred_taken_x;
  logic [31:0] pred_target_x;
  logic [31:0] PC_f;
  logic [31:0] PC_d;
  logic        valid_d;
  logic        pred_taken_d;
  logic [31:0] pred_target_d;
  logic        redirect;
  logic        flush;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state
  int unsigned m_ctr [4];
  logic [31:0] m_pcf, m_pcd, m_ptgt;
  logic        m_vd, m_pt;
  logic        m_mis, m_ptk;
  logic [31:0] m_rpc, m_pnext;

  pc_fetch_predict dut (
    .clk           (clk),
    .rst           (rst),
    .stall_f       (stall_f),
    .btb_target    (btb_target),
    .valid_x       (valid_x),
    .br_x          (br_x),
    .br_taken_x    (br_taken_x),
    .alu_out       (alu_out),
    .PC_x          (PC_x),
    .pred_taken_x  (pred_taken_x),
    .pred_target_x (pred_target_x),
    .PC_f          (PC_f),
    .PC_d          (PC_d),
    .valid_d       (valid_d),
    .pred_taken_d  (pred_taken_d),
    .pred_target_d (pred_target_d),
    .redirect      (redirect),
    .flush         (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_ctr[i] = 1;
    m_pcf = 32'h0; m_pcd = 32'h0; m_ptgt = 32'h0; m_vd = 1'b0; m_pt = 1'b0;
  endtask

  task automatic idle_x();
    valid_x = 0; br_x = 0; br_taken_x = 0; alu_out = 0; PC_x = 0;
    pred_taken_x = 0; pred_target_x = 0;
  endtask

  // One clock: check combinational outputs, advance model on the edge, check registers.
  task automatic cycle();
    int unsigned idx;
    #1;
    m_ptk   = (btb_target != m_pcf + 32'd4) && (m_ctr[m_pcf[3:2]] >= 2);
    m_pnext = m_ptk ? btb_target : m_pcf + 32'd4;
    m_mis   = valid_x && ((br_x && (br_taken_x != pred_taken_x)) ||
                          (br_x && br_taken_x && (alu_out != pred_target_x)) ||
                          (!br_x && pred_taken_x));
    m_rpc   = (br_x && br_taken_x) ? alu_out : PC_x + 32'd4;
    chk("redirect", 32'(redirect), 32'(m_mis));
    chk("flush", 32'(flush), 32'(m_mis));
    chk("pc_f_pre", PC_f, m_pcf);
    @(posedge clk);
    if (valid_x && br_x) begin
      idx = 32'(PC_x[3:2]);
      if (br_taken_x) m_ctr[idx] = (m_ctr[idx] == 3) ? 3 : m_ctr[idx] + 1;
      else            m_ctr[idx] = (m_ctr[idx] == 0) ? 0 : m_ctr[idx] - 1;
    end
    if (m_mis) begin
      m_pcf = m_rpc; m_vd = 1'b0;
    end else if (!stall_f) begin
      m_pcd = m_pcf; m_pt = m_ptk; m_ptgt = m_pnext; m_vd = 1'b1; m_pcf = m_pnext;
    end
    #1;
    chk("pc_f", PC_f, m_pcf);
    chk("valid_d", 32'(valid_d), 32'(m_vd));
    if (m_vd) begin
      chk("pc_d", PC_d, m_pcd);
      chk("pred_taken_d", 32'(pred_taken_d), 32'(m_pt));
      chk("pred_target_d", pred_target_d, m_ptgt);
    end
    @(negedge clk);
    idle_x();
    stall_f = 0;
    btb_target = m_pcf + 32'd4;
  endtask

  // Steer fetch to addr via a stale-alias redirect (no counter training).
  task automatic goto(input logic [31:0] addr);
    idle_x();
    valid_x = 1; pred_taken_x = 1; PC_x = addr - 32'd4;
    cycle();
  endtask

  // Correctly predicted branch at pc: trains the counter without redirecting.
  task automatic train(input logic [31:0] pc, input logic taken);
    valid_x = 1; br_x = 1; br_taken_x = taken; pred_taken_x = taken;
    alu_out = 32'h200; pred_target_x = 32'h200; PC_x = pc;
    cycle();
  endtask

  initial begin
    logic [31:0] r;
    rst = 0; stall_f = 0; btb_target = 32'h4;
    idle_x();
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_pc_f", PC_f, 32'h0);
    chk("rst_valid_d", 32'(valid_d), 32'h0);
    chk("rst_pc_d", PC_d, 32'h0);
    chk("rst_pred_taken_d", 32'(pred_taken_d), 32'h0);
    chk("rst_pred_target_d", pred_target_d, 32'h0);
    rst = 1;
    btb_target = m_pcf + 32'd4;

    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("seq_pc_f", PC_f, 32'(4 * (i + 1)));
      chk("seq_pc_d", PC_d, 32'(4 * i));
    end

    goto(32'h10);
    chk("goto_pc_f", PC_f, 32'h10);
    btb_target = 32'h40;
    cycle();
    chk("wnt_next", PC_f, 32'h14);
    chk("wnt_pt", 32'(pred_taken_d), 32'h0);
    train(32'h10, 1);
    train(32'h10, 1);
    goto(32'h10);
    btb_target = 32'h40;
    cycle();
    chk("st_next", PC_f, 32'h40);
    chk("st_pt", 32'(pred_taken_d), 32'h1);
    chk("st_tgt", pred_target_d, 32'h40);

    valid_x = 1; br_x = 1; br_taken_x = 1; alu_out = 32'h80; pred_taken_x = 0; PC_x = 32'h30;
    #1 chk("mis_redirect", 32'(redirect), 32'h1);
    cycle();
    chk("mis_pc_f", PC_f, 32'h80);
    chk("mis_valid_d", 32'(valid_d), 32'h0);
    valid_x = 1; br_x = 1; br_taken_x = 1; alu_out = 32'h80; pred_taken_x = 0; PC_x = 32'h30;
    stall_f = 1;
    cycle();
    chk("stall_redirect_pc_f", PC_f, 32'h80);

    valid_x = 1; br_x = 1; br_taken_x = 1; pred_taken_x = 1; pred_target_x = 32'h40;
    alu_out = 32'h44; PC_x = 32'h20;
    cycle();
    chk("tgt_mis_pc_f", PC_f, 32'h44);
    valid_x = 1; br_x = 1; br_taken_x = 1; pred_taken_x = 1; pred_target_x = 32'h40;
    alu_out = 32'h40; PC_x = 32'h20;
    #1 chk("tgt_ok_redirect", 32'(redirect), 32'h0);
    cycle();

    repeat (5) train(32'h4, 1);
    goto(32'h4);
    btb_target = 32'h100;
    cycle();
    chk("sat_hi_pt", 32'(pred_taken_d), 32'h1);
    repeat (5) train(32'h4, 0);
    train(32'h4, 1);
    goto(32'h4);
    btb_target = 32'h100;
    cycle();
    chk("sat_lo_pt", 32'(pred_taken_d), 32'h0);

    for (int n = 0; n < 400; n++) begin
      if (n == 200) begin
        #2 rst = 0;
        #1;
        model_reset();
        chk("mid_rst_pc_f", PC_f, 32'h0);
        chk("mid_rst_valid_d", 32'(valid_d), 32'h0);
        chk("mid_rst_pt", 32'(pred_taken_d), 32'h0);
        @(negedge clk);
        rst = 1;
        btb_target = 32'h100;
        cycle();
        chk("post_rst_pt", 32'(pred_taken_d), 32'h0);
      end
      r = $urandom;
      stall_f = ($urandom_range(0, 4) == 0);
      btb_target = ($urandom_range(0, 1) == 0) ? m_pcf + 32'd4 : {r[31:7], 5'b0, 2'b00};
      valid_x = ($urandom_range(0, 1) == 1);
      br_x = ($urandom_range(0, 3) != 0);
      br_taken_x = $urandom_range(0, 1) == 1;
      pred_taken_x = ($urandom_range(0, 3) == 0) ? !br_taken_x : br_taken_x;
      r = $urandom;
      PC_x = {24'h0, r[7:2], 2'b00};
      alu_out = {24'h0, r[15:10], 2'b00};
      pred_target_x = ($urandom_range(0, 3) == 0) ? alu_out + 32'd8 : alu_out;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1);
  end

endmodule

// File: doc/pc_fetch_predict.md
Name: pc_fetch_predict

Overview:
Fetch-stage PC generator sitting directly upstream of the branch target buffer. It drives PC_f into the BTB and consumes the BTB's BrTarget as the taken-path candidate. A 4-entry table of 2-bit saturating counters supplies the taken/not-taken decision. The block registers the fetch PC and its prediction into the IF/ID register, detects mispredictions reported by execute, and issues the redirect and flush.

Parameters:
- AWIDTH, 32, address/PC width
- RESET_PC, 32'h0000_0000, PC_f value after reset
- CTR_INIT, 2'b01, reset value of every direction counter (weakly not-taken)

Ports:
- clk, input, 1, system clock; all state updates on the rising edge
- rst, input, 1, reset: asynchronous, active-low
- stall_f, input, 1, hold PC_f and the IF/ID register
- btb_target, input, AWIDTH, BrTarget from the BTB for the current PC_f (equals PC_f+4 on a BTB miss)
- valid_x, input, 1, execute stage holds a valid instruction
- br_x, input, 1, execute instruction is a branch/jump (same signal that writes the BTB)
- br_taken_x, input, 1, resolved direction in execute
- alu_out, input, AWIDTH, resolved taken target in execute
- PC_x, input, AWIDTH, PC of the execute instruction
- pred_taken_x, input, 1, pred_taken_d carried through ID/EX
- pred_target_x, input, AWIDTH, pred_target_d carried through ID/EX
- PC_f, output, AWIDTH, current fetch PC, sent to I-mem and the BTB
- PC_d, output, AWIDTH, IF/ID registered PC
- valid_d, output, 1, IF/ID valid
- pred_taken_d, output, 1, IF/ID registered prediction
- pred_target_d, output, AWIDTH, IF/ID registered predicted next PC
- redirect, output, 1, combinational mispredict indication
- flush, output, 1, combinational kill of the F and D stages (equals redirect)

Behaviour:
- Reset (rst=0, asynchronous): PC_f=RESET_PC, PC_d=0, valid_d=0, pred_taken_d=0, pred_target_d=0, all 4 counters=CTR_INIT. Reset applied mid-operation discards every in-flight prediction. The first fetch after release is at RESET_PC.
- Lookup (combinational):
  - idx_f = PC_f[3:2], the same indexing as the BTB.
  - btb_hit = (btb_target != PC_f+4).
  - pred_taken_f = btb_hit && ctr[idx_f][1].
  - pred_next_f = pred_taken_f ? btb_target : PC_f+4.
  - All adds are AWIDTH-bit and wrap modulo 2^AWIDTH with no carry out.
- Mispredict detection (combinational, only when valid_x=1):
  - br_x=1 and br_taken_x != pred_taken_x, or
  - br_x=1, br_taken_x=1 and alu_out != pred_target_x, or
  - br_x=0 and pred_taken_x=1 (stale alias).
  - redirect = flush = the OR of these terms, gated by valid_x.
  - redirect_pc = (br_x && br_taken_x) ? alu_out : PC_x+4.
- Next-PC priority each edge: redirect -> redirect_pc; else stall_f -> hold; else pred_next_f.
- IF/ID register:
  - On redirect: valid_d<=0 and the other fields are don't-care (hold them).
  - Else on stall_f: hold every field.
  - Else: PC_d<=PC_f, pred_taken_d<=pred_taken_f, pred_target_d<=pred_next_f, valid_d<=1.
- Counter update on the edge when valid_x && br_x:
  - Index PC_x[3:2].
  - Taken: increment, saturating at 11. Not taken: decrement, saturating at 00.
  - Updates proceed regardless of stall_f and redirect.
- Simultaneous events:
  - Update and lookup on the same index in one cycle: the lookup sees the pre-edge value, with no bypass.
  - redirect overrides stall_f.
  - Two branches aliasing to one index share a counter; this is accepted.
- Latency: prediction available in the same cycle as PC_f. Mispredict penalty is 2 cycles (F and D squashed).

Decomposition:
- Shared package holds: the AWIDTH default; the counter encodings SNT=00, WNT=01, WT=10, ST=11; and the PC increment constant 4.
- One sub-module, sat_counter_table: a 4x2-bit array with async-low reset, one read port and one saturating update port.

Test Plan:
- Reset release with RESET_PC=0, stall_f=0, no branches -> PC_f sequence 0,4,8,C; valid_d=1 from the second cycle; PC_d lags PC_f by one cycle.
- PC_f=0x10 with btb_target=0x40 and counter[0]=WNT -> next PC_f=0x14, pred_taken_d=0. After two taken updates on PC_x=0x10 (counter reaches ST), PC_f=0x10 -> next PC_f=0x40, pred_taken_d=1, pred_target_d=0x40.
- valid_x=1, br_x=1, br_taken_x=1, alu_out=0x80, pred_taken_x=0 -> redirect=flush=1 that cycle; next PC_f=0x80, valid_d=0. Same case with stall_f=1 -> redirect still wins.
- pred_taken_x=1, pred_target_x=0x40, br_taken_x=1, alu_out=0x44 -> redirect to 0x44. Same case with alu_out=0x40 -> redirect=0.
- Saturation: five taken updates to index 1 -> counter stays at 11; five not-taken updates -> counter stays at 00. Assert rst low mid-stream -> PC_f=RESET_PC and all counters=01 immediately, with no clock edge needed.
